// File: rtl/imem_responder_if.sv
// Instruction-fetch request/response handshake plus loader write port
// between the core (master) and the instruction memory responder (slave).
interface imem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_inst_o;
  logic        rsp_err_o;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: one 32-bit word per accepted fetch request,
// after WAIT_CYCLES wait states, with a loader write port to fill the array.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_inst_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [31:0] rd_word;
  logic        rd_err;

  assign bus.req_ready_o = (state == S_IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_inst_o  = rsp_inst_q;

  // In IDLE the read uses the live request address so WAIT_CYCLES==0 can
  // read in the accept cycle; otherwise the captured address is used.
  always_comb begin
    rd_addr = (state == S_IDLE) ? bus.req_addr_i : addr_q;
    rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= DEPTH_LIM);
    rd_word = mem[rd_addr[IDX_W+1:2]];
  end

  // Memory is never reset; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (bus.ld_we_i && (bus.ld_addr_i[31:2] < DEPTH_LIM)) begin
      mem[bus.ld_addr_i[IDX_W+1:2]] <= bus.ld_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_inst_q  <= NOP_INST;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            addr_q <= bus.req_addr_i;
            if (WAIT_CYCLES == 0) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= rd_err;
              rsp_inst_q  <= rd_err ? NOP_INST : rd_word;
              state       <= S_RESP;
            end else begin
              wait_cnt <= WAIT_INIT;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rd_err;
            rsp_inst_q  <= rd_err ? NOP_INST : rd_word;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with one wait state and
// one with zero wait states, sharing clock and reset.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if bus1 ();
  imem_responder_if bus0 ();

  imem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(1), .NOP_INST(32'h00000013)) u_dut_w1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  imem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0), .NOP_INST(32'h00000013)) u_dut_w0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  localparam logic [31:0] NOP = 32'h00000013;

  int passed = 0;
  int total  = 0;
  logic [31:0] prog [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};

  task automatic drive_idle();
    bus1.req_valid_i = 1'b0; bus1.req_addr_i = '0; bus1.rsp_ready_i = 1'b0;
    bus1.ld_we_i = 1'b0; bus1.ld_addr_i = '0; bus1.ld_data_i = '0;
    bus0.req_valid_i = 1'b0; bus0.req_addr_i = '0; bus0.rsp_ready_i = 1'b0;
    bus0.ld_we_i = 1'b0; bus0.ld_addr_i = '0; bus0.ld_data_i = '0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus1.ld_we_i = 1'b1; bus1.ld_addr_i = a; bus1.ld_data_i = d;
    bus0.ld_we_i = 1'b1; bus0.ld_addr_i = a; bus0.ld_data_i = d;
    @(posedge clk); #1;
    bus1.ld_we_i = 1'b0;
    bus0.ld_we_i = 1'b0;
  endtask

  // Issue one fetch, wait (bounded) for the response, acknowledge it.
  task automatic fetch(input bit on_w0, input logic [31:0] a,
                       output logic [31:0] inst, output logic err, output int lat);
    if (on_w0) begin
      bus0.req_valid_i = 1'b1; bus0.req_addr_i = a;
    end else begin
      bus1.req_valid_i = 1'b1; bus1.req_addr_i = a;
    end
    @(posedge clk); #1;
    bus0.req_valid_i = 1'b0;
    bus1.req_valid_i = 1'b0;
    lat = 1;
    while (!(on_w0 ? bus0.rsp_valid_o : bus1.rsp_valid_o) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    inst = on_w0 ? bus0.rsp_inst_o : bus1.rsp_inst_o;
    err  = on_w0 ? bus0.rsp_err_o  : bus1.rsp_err_o;
    bus0.rsp_ready_i = 1'b1;
    bus1.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready_i = 1'b0;
    bus1.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (bus1.rsp_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus1.rsp_valid_o); else passed++;
    total++; if (bus1.rsp_inst_o !== NOP) $display("FAIL reset_inst: got %h expected %h", bus1.rsp_inst_o, NOP); else passed++;
    total++; if (bus1.rsp_err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus1.rsp_err_o); else passed++;
    total++; if (bus1.req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus1.req_ready_o); else passed++;
    total++; if (bus0.rsp_inst_o !== NOP) $display("FAIL reset_inst_w0: got %h expected %h", bus0.rsp_inst_o, NOP); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    for (int unsigned i = 0; i < 4; i++) load_word(32'(i * 4), prog[i]);
    load_word(32'h00003FFC, 32'hCAFEF00D);
    load_word(32'h00004000, 32'hBADBAD00);
  endtask

  task automatic test_fetch_latency();
    logic [31:0] inst; logic err; int lat;
    total++; if (bus1.req_ready_o !== 1'b1) $display("FAIL lat_ready: got %b expected 1", bus1.req_ready_o); else passed++;
    fetch(1'b0, 32'h8, inst, err, lat);
    total++; if (lat !== 2) $display("FAIL lat_w1: got %0d expected 2", lat); else passed++;
    total++; if (inst !== 32'h002081B3) $display("FAIL lat_w1_inst: got %h expected 002081b3", inst); else passed++;
    total++; if (err !== 1'b0) $display("FAIL lat_w1_err: got %b expected 0", err); else passed++;
    fetch(1'b1, 32'h4, inst, err, lat);
    total++; if (lat !== 1) $display("FAIL lat_w0: got %0d expected 1", lat); else passed++;
    total++; if (inst !== 32'h00100113) $display("FAIL lat_w0_inst: got %h expected 00100113", inst); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    bus1.req_valid_i = 1'b1; bus1.req_addr_i = 32'h0;
    @(posedge clk); #1;
    bus1.req_valid_i = 1'b0;
    n = 0;
    while (!bus1.rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (bus1.rsp_valid_o !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", bus1.rsp_valid_o); else passed++;
    for (int unsigned k = 0; k < 5; k++) begin
      bus1.req_valid_i = 1'b1;
      bus1.req_addr_i  = 32'((k + 1) * 4);
      @(posedge clk); #1;
      total++; if (bus1.rsp_valid_o !== 1'b1) $display("FAIL bp_valid_hold: cycle %0d got %b expected 1", k, bus1.rsp_valid_o); else passed++;
      total++; if (bus1.rsp_inst_o !== 32'h00500093) $display("FAIL bp_inst_hold: cycle %0d got %h expected 00500093", k, bus1.rsp_inst_o); else passed++;
      total++; if (bus1.req_ready_o !== 1'b0) $display("FAIL bp_ready_low: cycle %0d got %b expected 0", k, bus1.req_ready_o); else passed++;
    end
    bus1.req_valid_i = 1'b0;
    bus1.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready_i = 1'b0;
    total++; if (bus1.rsp_valid_o !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", bus1.rsp_valid_o); else passed++;
    total++; if (bus1.req_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus1.req_ready_o); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] inst; logic err; int lat;
    logic [31:0] bad [2] = '{32'h00000006, 32'h00004000};
    for (int unsigned i = 0; i < 2; i++) begin
      fetch(1'b0, bad[i], inst, err, lat);
      total++; if (err !== 1'b1) $display("FAIL err_flag: addr %h got %b expected 1", bad[i], err); else passed++;
      total++; if (inst !== NOP) $display("FAIL err_inst: addr %h got %h expected %h", bad[i], inst, NOP); else passed++;
    end
    fetch(1'b0, 32'h00003FFC, inst, err, lat);
    total++; if (err !== 1'b0) $display("FAIL last_word_err: got %b expected 0", err); else passed++;
    total++; if (inst !== 32'hCAFEF00D) $display("FAIL last_word_inst: got %h expected cafef00d", inst); else passed++;
    fetch(1'b0, 32'h0, inst, err, lat);
    total++; if (inst !== 32'h00500093) $display("FAIL ld_drop_oob: got %h expected 00500093", inst); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] got [$];
    int          seen [$];
    logic [31:0] a;
    bit          acc;
    a = 32'h0;
    bus0.rsp_ready_i = 1'b1;
    bus0.req_valid_i = 1'b1;
    bus0.req_addr_i  = a;
    for (int c = 0; c < 14; c++) begin
      acc = bus0.req_valid_i && bus0.req_ready_o;
      @(posedge clk); #1;
      if (bus0.rsp_valid_o) begin
        got.push_back(bus0.rsp_inst_o);
        seen.push_back(c);
      end
      if (acc) begin
        a = a + 32'h4;
        if (a == 32'h10) bus0.req_valid_i = 1'b0;
        else bus0.req_addr_i = a;
      end
    end
    bus0.rsp_ready_i = 1'b0;
    total++; if (got.size() !== 4) $display("FAIL stream_count: got %0d expected 4", got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== prog[i]) $display("FAIL stream_inst: idx %0d got %h expected %h", i, got[i], prog[i]); else passed++;
        if (i > 0) begin
          total++; if (seen[i] - seen[i-1] !== 2) $display("FAIL stream_spacing: idx %0d got %0d expected 2", i, seen[i] - seen[i-1]); else passed++;
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] inst; logic err; int lat;
    bus0.req_valid_i = 1'b1; bus0.req_addr_i = 32'h8;
    bus0.ld_we_i = 1'b1; bus0.ld_addr_i = 32'h8; bus0.ld_data_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus0.req_valid_i = 1'b0;
    bus0.ld_we_i = 1'b0;
    total++; if (bus0.rsp_valid_o !== 1'b1) $display("FAIL coll_valid: got %b expected 1", bus0.rsp_valid_o); else passed++;
    total++; if (bus0.rsp_inst_o !== 32'h002081B3) $display("FAIL coll_old_data: got %h expected 002081b3", bus0.rsp_inst_o); else passed++;
    bus0.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready_i = 1'b0;
    fetch(1'b1, 32'h8, inst, err, lat);
    total++; if (inst !== 32'hDEADBEEF) $display("FAIL coll_new_data: got %h expected deadbeef", inst); else passed++;
  endtask

  task automatic test_reset_mid_resp();
    logic [31:0] inst; logic err; int lat; int n;
    bus1.req_valid_i = 1'b1; bus1.req_addr_i = 32'hC;
    @(posedge clk); #1;
    bus1.req_valid_i = 1'b0;
    n = 0;
    while (!bus1.rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (bus1.rsp_valid_o !== 1'b1) $display("FAIL rst_pre_valid: got %b expected 1", bus1.rsp_valid_o); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (bus1.rsp_valid_o !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", bus1.rsp_valid_o); else passed++;
    total++; if (bus1.rsp_inst_o !== NOP) $display("FAIL rst_mid_inst: got %h expected %h", bus1.rsp_inst_o, NOP); else passed++;
    total++; if (bus1.req_ready_o !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", bus1.req_ready_o); else passed++;
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (bus1.rsp_valid_o !== 1'b0) $display("FAIL rst_no_rsp: cycle %0d got %b expected 0", k, bus1.rsp_valid_o); else passed++;
    end
    fetch(1'b0, 32'hC, inst, err, lat);
    total++; if (inst !== 32'h0000006F) $display("FAIL rst_mem_kept: got %h expected 0000006f", inst); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_mem_err: got %b expected 0", err); else passed++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load();
    test_fetch_latency();
    test_backpressure();
    test_errors();
    test_stream();
    test_collision();
    test_reset_mid_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
